mdu_issue_ctrl: RTL and testbench

EX-stage initiator for the multiply/divide unit.
- Accepts decoded HI/LO-class instructions from the pipeline and drives the MDU's operation and operand inputs.
- Tracks multiply/divide latency with a local counter and raises a pipeline stall for any HI/LO instruction that would collide with an in-flight operation.
- Returns HI/LO read data for MFHI/MFLO.

---
 rtl/mdu_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// ============================================================================
// mdu_issue_ctrl -- EX-stage initiator for the multiply/divide unit.
//
// Accepts decoded HI/LO-class instructions, issues a one-cycle operation
// pulse with operands to the MDU, tracks mult/div latency with a local
// down-counter and stalls the pipeline for any HI/LO instruction that would
// collide with an in-flight operation. MFHI/MFLO return MDU HI/LO data
// combinationally in their accept cycle.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   i_valid, i_op     EX instruction valid and decoded class (0..8)
//   i_rs_data/rt_data forwarded source operands
//   i_flush           kill the EX instruction this cycle
//   mdu_busy/hi/lo    MDU status and result registers
//   o_mdu_op          one-cycle operation pulse to the MDU
//   o_mdu_operand1/2  operands to the MDU (held after issue)
//   o_stall           freeze IF/ID/EX this cycle
//   o_read_data       HI/LO value for an accepted MFHI/MFLO, else 0
//   o_stall_cycles    stall-cycle counter
//
// Build option: define MDU_ISSUE_PERF_EN to enable the o_stall_cycles
// counter; otherwise o_stall_cycles is tied to 0.
// ============================================================================
module mdu_issue_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   input  logic [3:0]  i_op,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   input  logic        i_flush,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_hi,
   input  logic [31:0] mdu_lo,
   output logic [3:0]  o_mdu_op,
   output logic [31:0] o_mdu_operand1,
   output logic [31:0] o_mdu_operand2,
   output logic        o_stall,
   output logic [31:0] o_read_data,
   output logic [31:0] o_stall_cycles
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [31:0]      opnd1_q, opnd1_d;
   logic [31:0]      opnd2_q, opnd2_d;

   logic op_known;
   logic accept;
   logic issue;

   // Codes above 8 are treated as "none": never accepted, never stall.
   assign op_known = (i_op != OP_NONE) && (i_op <= OP_MTLO);
   assign o_stall  = i_valid && !i_flush && op_known &&
                     ((state_q != S_IDLE) || mdu_busy);
   assign accept   = i_valid && !i_flush && op_known && !o_stall;
   // Reads are serviced locally; everything else goes to the MDU.
   assign issue    = accept && (i_op != OP_MFHI) && (i_op != OP_MFLO);

   always_comb begin
      o_read_data = 32'd0;
      if (accept && (i_op == OP_MFHI)) o_read_data = mdu_hi;
      if (accept && (i_op == OP_MFLO)) o_read_data = mdu_lo;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = OP_NONE;   // op is a pulse: it only survives the ISSUE cycle
      opnd1_d = opnd1_q;
      opnd2_d = opnd2_q;
      case (state_q)
         S_IDLE: begin
            if (issue) begin
               state_d = S_ISSUE;
               op_d    = i_op;
               opnd1_d = i_rs_data;
               opnd2_d = i_rt_data;
            end
         end
         S_ISSUE: begin
            // op_q still holds the class issued last cycle.
            if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
               cnt_d   = CNT_W'(MULT_CYCLES);
               state_d = (MULT_CYCLES == 0) ? S_IDLE : S_BUSY;
            end else if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
               cnt_d   = CNT_W'(DIV_CYCLES);
               state_d = (DIV_CYCLES == 0) ? S_IDLE : S_BUSY;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            // Leave on the same edge as the 1->0 count transition.
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NONE;
         opnd1_q <= 32'd0;
         opnd2_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd1_q <= opnd1_d;
         opnd2_q <= opnd2_d;
      end
   end

   assign o_mdu_op       = op_q;
   assign o_mdu_operand1 = opnd1_q;
   assign o_mdu_operand2 = opnd2_q;

`ifdef MDU_ISSUE_PERF_EN
   logic [31:0] stall_cnt_q;

   // Free-running, wraps modulo 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else if (o_stall) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign o_stall_cycles = stall_cnt_q;
`else
   assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
module tb_mdu_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        i_valid;
   logic [3:0]  i_op;
   logic [31:0] i_rs_data;
   logic [31:0] i_rt_data;
   logic        i_flush;
   logic        mdu_busy;
   logic [31:0] mdu_hi;
   logic [31:0] mdu_lo;
   logic [3:0]  o_mdu_op;
   logic [31:0] o_mdu_operand1;
   logic [31:0] o_mdu_operand2;
   logic        o_stall;
   logic [31:0] o_read_data;
   logic [31:0] o_stall_cycles;

   int checks = 0;
   int errors = 0;

   mdu_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_valid        (i_valid),
      .i_op           (i_op),
      .i_rs_data      (i_rs_data),
      .i_rt_data      (i_rt_data),
      .i_flush        (i_flush),
      .mdu_busy       (mdu_busy),
      .mdu_hi         (mdu_hi),
      .mdu_lo         (mdu_lo),
      .o_mdu_op       (o_mdu_op),
      .o_mdu_operand1 (o_mdu_operand1),
      .o_mdu_operand2 (o_mdu_operand2),
      .o_stall        (o_stall),
      .o_read_data    (o_read_data),
      .o_stall_cycles (o_stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple MDU stand-in: result lands one edge after the op pulse.
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   always_comb begin
      prod_s = $signed({{32{o_mdu_operand1[31]}}, o_mdu_operand1}) *
               $signed({{32{o_mdu_operand2[31]}}, o_mdu_operand2});
      prod_u = {32'd0, o_mdu_operand1} * {32'd0, o_mdu_operand2};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mdu_hi <= 32'd0;
         mdu_lo <= 32'd0;
      end else begin
         case (o_mdu_op)
            4'd1: begin mdu_hi <= prod_s[63:32]; mdu_lo <= prod_s[31:0]; end
            4'd2: begin mdu_hi <= prod_u[63:32]; mdu_lo <= prod_u[31:0]; end
            4'd3: if (o_mdu_operand2 != 0) begin
                     mdu_hi <= $signed(o_mdu_operand1) % $signed(o_mdu_operand2);
                     mdu_lo <= $signed(o_mdu_operand1) / $signed(o_mdu_operand2);
                  end
            4'd4: if (o_mdu_operand2 != 0) begin
                     mdu_hi <= o_mdu_operand1 % o_mdu_operand2;
                     mdu_lo <= o_mdu_operand1 / o_mdu_operand2;
                  end
            4'd7: mdu_hi <= o_mdu_operand1;
            4'd8: mdu_lo <= o_mdu_operand1;
            default: ;
         endcase
      end
   end

   typedef struct {
      logic        valid;
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        flush;
      logic        busy;
      logic        exp_stall;
      logic [3:0]  exp_op;
      logic [31:0] exp_rd;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   function automatic vec_t mk(logic v, logic [3:0] op, logic [31:0] rs, logic [31:0] rt,
                               logic fl, logic bz, logic es, logic [3:0] eo, logic [31:0] er);
      vec_t r;
      r.valid = v; r.op = op; r.rs = rs; r.rt = rt; r.flush = fl; r.busy = bz;
      r.exp_stall = es; r.exp_op = eo; r.exp_rd = er;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fl);
      i_valid = v; i_op = op; i_rs_data = rs; i_rt_data = rt; i_flush = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int n;
   bit done;
   logic [31:0] base;

   initial begin
      reset = 1'b1;
      mdu_busy = 1'b0;
      drive(0, 4'd0, 32'd0, 32'd0, 0);

      // Reset state
      @(negedge clk);
      chk("rst_op", {28'd0, o_mdu_op}, 32'd0);
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_rd", o_read_data, 32'd0);
      chk("rst_perf", o_stall_cycles, 32'd0);
      tick();
      reset = 1'b0;

      //               v  op     rs            rt            fl bz  st eo     rd
      tbl[0]  = mk(1, 4'd1, 32'd3,        32'hFFFFFFFC, 0, 0, 0, 4'd0, 32'd0);
      tbl[1]  = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 1, 4'd1, 32'd0);
      tbl[2]  = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 1, 4'd0, 32'd0);
      tbl[3]  = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 1, 4'd0, 32'd0);
      tbl[4]  = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 1, 4'd0, 32'd0);
      tbl[5]  = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 1, 4'd0, 32'd0);
      tbl[6]  = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 1, 4'd0, 32'd0);
      tbl[7]  = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'hFFFFFFF4);
      tbl[8]  = mk(1, 4'd5, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'hFFFFFFFF);
      tbl[9]  = mk(0, 4'd0, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'd0);
      tbl[10] = mk(1, 4'd7, 32'hDEADBEEF, 32'd0,        0, 0, 0, 4'd0, 32'd0);
      tbl[11] = mk(1, 4'd5, 32'd0,        32'd0,        0, 0, 1, 4'd7, 32'd0);
      tbl[12] = mk(1, 4'd5, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'hDEADBEEF);
      tbl[13] = mk(1, 4'd1, 32'd2,        32'd5,        1, 0, 0, 4'd0, 32'd0);
      tbl[14] = mk(0, 4'd0, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'd0);
      tbl[15] = mk(1, 4'd1, 32'd2,        32'd5,        0, 0, 0, 4'd0, 32'd0);
      tbl[16] = mk(0, 4'd0, 32'd0,        32'd0,        0, 0, 0, 4'd1, 32'd0);
      tbl[17] = mk(1, 4'd1, 32'd9,        32'd9,        1, 0, 0, 4'd0, 32'd0);
      tbl[18] = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 1, 4'd0, 32'd0);
      tbl[19] = mk(0, 4'd0, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'd0);
      tbl[20] = mk(0, 4'd0, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'd0);
      tbl[21] = mk(0, 4'd0, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'd0);
      tbl[22] = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'd10);
      tbl[23] = mk(1, 4'd9, 32'd1,        32'd1,        0, 0, 0, 4'd0, 32'd0);
      tbl[24] = mk(1, 4'd15,32'd1,        32'd1,        0, 0, 0, 4'd0, 32'd0);
      tbl[25] = mk(1, 4'd6, 32'd0,        32'd0,        0, 1, 1, 4'd0, 32'd0);
      tbl[26] = mk(1, 4'd6, 32'd0,        32'd0,        0, 0, 0, 4'd0, 32'd10);

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].valid, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].flush);
         mdu_busy = tbl[i].busy;
         @(negedge clk);
         chk($sformatf("v%0d_stall", i), {31'd0, o_stall}, {31'd0, tbl[i].exp_stall});
         chk($sformatf("v%0d_op", i), {28'd0, o_mdu_op}, {28'd0, tbl[i].exp_op});
         chk($sformatf("v%0d_rd", i), o_read_data, tbl[i].exp_rd);
         tick();
      end
      drive(0, 4'd0, 32'd0, 32'd0, 0);
      mdu_busy = 1'b0;

      // DIVU followed by a non-MDU stream, then reads 12 cycles later
      drive(1, 4'd4, 32'd100, 32'd7, 0);
      @(negedge clk);
      chk("divu_accept_stall", {31'd0, o_stall}, 32'd0);
      tick();
      for (int k = 1; k < 12; k++) begin
         drive(1, (k % 2 == 1) ? 4'd0 : 4'd9, 32'(k), 32'(k), 0);
         @(negedge clk);
         chk($sformatf("divu_stream%0d_stall", k), {31'd0, o_stall}, 32'd0);
         if (k == 1) chk("divu_pulse", {28'd0, o_mdu_op}, 32'd4);
         if (k == 2) chk("divu_pulse_end", {28'd0, o_mdu_op}, 32'd0);
         tick();
      end
      drive(1, 4'd5, 32'd0, 32'd0, 0);
      @(negedge clk);
      chk("divu_mfhi_stall", {31'd0, o_stall}, 32'd0);
      chk("divu_mfhi_rd", o_read_data, 32'd2);
      tick();
      drive(1, 4'd6, 32'd0, 32'd0, 0);
      @(negedge clk);
      chk("divu_mflo_stall", {31'd0, o_stall}, 32'd0);
      chk("divu_mflo_rd", o_read_data, 32'd14);
      tick();

      // DIV interrupted by reset in BUSY cycle 3
      drive(1, 4'd3, 32'hFFFFFFEC, 32'd3, 0);
      tick();
      drive(0, 4'd0, 32'd0, 32'd0, 0);
      tick();   // ISSUE
      tick();   // BUSY 1
      tick();   // BUSY 2
      drive(1, 4'd6, 32'd0, 32'd0, 0);
      @(negedge clk);
      chk("rstmid_pre_stall", {31'd0, o_stall}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rstmid_stall", {31'd0, o_stall}, 32'd0);
      chk("rstmid_op", {28'd0, o_mdu_op}, 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rstmid_mflo_stall", {31'd0, o_stall}, 32'd0);
      chk("rstmid_mflo_rd", o_read_data, 32'd0);
      tick();
      drive(0, 4'd0, 32'd0, 32'd0, 0);
      tick();

      // MULT then MFHI: stall length and stall-cycle counter
      base = o_stall_cycles;
      drive(1, 4'd1, 32'd3, 32'hFFFFFFFC, 0);
      tick();
      drive(1, 4'd5, 32'd0, 32'd0, 0);
      n = 0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (o_stall) begin
            n++;
            tick();
         end else begin
            done = 1'b1;
         end
      end
      chk("perf_stall_len", 32'(n), 32'd6);
      chk("perf_mfhi_rd", o_read_data, 32'hFFFFFFFF);
`ifdef MDU_ISSUE_PERF_EN
      chk("perf_cnt_delta", o_stall_cycles - base, 32'd6);
`else
      chk("perf_cnt_zero", o_stall_cycles, 32'd0);
`endif
      tick();
      drive(0, 4'd0, 32'd0, 32'd0, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
